// File: rtl/decode_stage.sv
// Decode stage: register file, immediate generation, control decode, early
// branch/jump resolution and the D->E pipeline register.
module decode_stage #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [31:0]     InstrD,
  input  logic [XLEN-1:0] PCPlus4D,
  input  logic            RegWriteW,
  input  logic [4:0]      RdW,
  input  logic [XLEN-1:0] ResultW,
  input  logic [XLEN-1:0] ALUOutM,
  input  logic            ForwardAD,
  input  logic            ForwardBD,
  input  logic            FlushE,
  output logic            PCSrcD,
  output logic [XLEN-1:0] PCBranchD,
  output logic [4:0]      Rs1D,
  output logic [4:0]      Rs2D,
  output logic            RegWriteE,
  output logic            MemWriteE,
  output logic            ALUSrcE,
  output logic [1:0]      ResultSrcE,
  output logic [3:0]      ALUControlE,
  output logic [XLEN-1:0] RD1E,
  output logic [XLEN-1:0] RD2E,
  output logic [XLEN-1:0] ImmExtE,
  output logic [XLEN-1:0] PCPlus4E,
  output logic [4:0]      RdE,
  output logic [4:0]      Rs1E,
  output logic [4:0]      Rs2E
);

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_BR   = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam logic [6:0] OP_LUI  = 7'b0110111;

  localparam logic [3:0] ALU_ADD = 4'b0000, ALU_SUB = 4'b0001, ALU_AND = 4'b0010,
                         ALU_OR  = 4'b0011, ALU_XOR = 4'b0100, ALU_SLT = 4'b0101,
                         ALU_SLL = 4'b0110, ALU_SRL = 4'b0111, ALU_SRA = 4'b1000,
                         ALU_PSB = 4'b1001;

  logic [6:0] op;
  logic [2:0] f3;
  logic [6:0] f7;
  logic [4:0] rd;
  assign op   = InstrD[6:0];
  assign rd   = InstrD[11:7];
  assign f3   = InstrD[14:12];
  assign f7   = InstrD[31:25];
  assign Rs1D = InstrD[19:15];
  assign Rs2D = InstrD[24:20];

  logic [XLEN-1:0] rf_q [NREGS];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) rf_q[i] <= '0;
    end else if (RegWriteW && RdW != 5'd0) begin
      rf_q[RdW] <= ResultW;
    end
  end

  // Write-through so a same-cycle writeback is visible to both E capture and compare.
  logic [XLEN-1:0] rd1, rd2;
  always_comb begin
    rd1 = '0;
    rd2 = '0;
    if (Rs1D != 5'd0) rd1 = (RegWriteW && RdW == Rs1D) ? ResultW : rf_q[Rs1D];
    if (Rs2D != 5'd0) rd2 = (RegWriteW && RdW == Rs2D) ? ResultW : rf_q[Rs2D];
  end

  logic            reg_write, mem_write, alu_src;
  logic [1:0]      result_src;
  logic [3:0]      alu_ctl;
  logic [XLEN-1:0] imm_ext;
  logic            is_beq, is_bne, is_jal, is_jalr;

  always_comb begin
    reg_write  = 1'b0;
    mem_write  = 1'b0;
    alu_src    = 1'b0;
    result_src = 2'b00;
    alu_ctl    = ALU_ADD;
    imm_ext    = '0;
    is_beq     = 1'b0;
    is_bne     = 1'b0;
    is_jal     = 1'b0;
    is_jalr    = 1'b0;
    case (op)
      OP_R: begin
        reg_write = 1'b1;
        case ({f7, f3})
          {7'h00, 3'b000}: alu_ctl = ALU_ADD;
          {7'h20, 3'b000}: alu_ctl = ALU_SUB;
          {7'h00, 3'b001}: alu_ctl = ALU_SLL;
          {7'h00, 3'b010}: alu_ctl = ALU_SLT;
          {7'h00, 3'b100}: alu_ctl = ALU_XOR;
          {7'h00, 3'b101}: alu_ctl = ALU_SRL;
          {7'h20, 3'b101}: alu_ctl = ALU_SRA;
          {7'h00, 3'b110}: alu_ctl = ALU_OR;
          {7'h00, 3'b111}: alu_ctl = ALU_AND;
          default:         reg_write = 1'b0;
        endcase
      end
      OP_I: begin
        reg_write = 1'b1;
        alu_src   = 1'b1;
        imm_ext   = {{(XLEN-12){InstrD[31]}}, InstrD[31:20]};
        case (f3)
          3'b000: alu_ctl = ALU_ADD;
          3'b010: alu_ctl = ALU_SLT;
          3'b100: alu_ctl = ALU_XOR;
          3'b110: alu_ctl = ALU_OR;
          3'b111: alu_ctl = ALU_AND;
          default: begin
            // Shift immediates carry only the 5-bit shamt.
            imm_ext = {{(XLEN-5){1'b0}}, InstrD[24:20]};
            if (f3 == 3'b001 && f7 == 7'h00)      alu_ctl = ALU_SLL;
            else if (f3 == 3'b101 && f7 == 7'h00) alu_ctl = ALU_SRL;
            else if (f3 == 3'b101 && f7 == 7'h20) alu_ctl = ALU_SRA;
            else begin
              reg_write = 1'b0;
              alu_src   = 1'b0;
              imm_ext   = '0;
            end
          end
        endcase
      end
      OP_LW: if (f3 == 3'b010) begin
        reg_write  = 1'b1;
        alu_src    = 1'b1;
        result_src = 2'b01;
        imm_ext    = {{(XLEN-12){InstrD[31]}}, InstrD[31:20]};
      end
      OP_SW: if (f3 == 3'b010) begin
        mem_write = 1'b1;
        alu_src   = 1'b1;
        imm_ext   = {{(XLEN-12){InstrD[31]}}, InstrD[31:25], InstrD[11:7]};
      end
      OP_BR: if (f3 == 3'b000 || f3 == 3'b001) begin
        is_beq  = (f3 == 3'b000);
        is_bne  = (f3 == 3'b001);
        imm_ext = {{(XLEN-12){InstrD[31]}}, InstrD[7], InstrD[30:25], InstrD[11:8], 1'b0};
      end
      OP_JAL: begin
        is_jal     = 1'b1;
        reg_write  = 1'b1;
        result_src = 2'b10;
        imm_ext    = {{(XLEN-20){InstrD[31]}}, InstrD[19:12], InstrD[20], InstrD[30:21], 1'b0};
      end
      OP_JALR: if (f3 == 3'b000) begin
        is_jalr    = 1'b1;
        reg_write  = 1'b1;
        alu_src    = 1'b1;
        result_src = 2'b10;
        imm_ext    = {{(XLEN-12){InstrD[31]}}, InstrD[31:20]};
      end
      OP_LUI: begin
        reg_write = 1'b1;
        alu_src   = 1'b1;
        alu_ctl   = ALU_PSB;
        imm_ext   = {{(XLEN-32){InstrD[31]}}, InstrD[31:12], 12'b0};
      end
      default: ;
    endcase
  end

  logic [XLEN-1:0] cmp_a, cmp_b, pc_d;
  logic            eq;
  assign pc_d      = PCPlus4D - XLEN'(4);
  assign cmp_a     = ForwardAD ? ALUOutM : rd1;
  assign cmp_b     = ForwardBD ? ALUOutM : rd2;
  assign eq        = (cmp_a == cmp_b);
  assign PCSrcD    = (is_beq & eq) | (is_bne & ~eq) | is_jal | is_jalr;
  assign PCBranchD = is_jalr ? ((cmp_a + imm_ext) & ~XLEN'(1)) : (pc_d + imm_ext);

  // D->E boundary: bubble on reset or flush, otherwise capture decode results.
  always_ff @(posedge clk) begin
    if (reset || FlushE) begin
      RegWriteE   <= 1'b0;
      MemWriteE   <= 1'b0;
      ALUSrcE     <= 1'b0;
      ResultSrcE  <= 2'b00;
      ALUControlE <= 4'b0000;
      RD1E        <= '0;
      RD2E        <= '0;
      ImmExtE     <= '0;
      PCPlus4E    <= '0;
      RdE         <= '0;
      Rs1E        <= '0;
      Rs2E        <= '0;
    end else begin
      RegWriteE   <= reg_write;
      MemWriteE   <= mem_write;
      ALUSrcE     <= alu_src;
      ResultSrcE  <= result_src;
      ALUControlE <= alu_ctl;
      RD1E        <= rd1;
      RD2E        <= rd2;
      ImmExtE     <= imm_ext;
      PCPlus4E    <= PCPlus4D;
      RdE         <= rd;
      Rs1E        <= Rs1D;
      Rs2E        <= Rs2D;
    end
  end

endmodule
